fmac_seq: RTL
=============

// Module: fmac_seq
// PURPOSE
//  Sequencing/handshake stage wrapped around the combinational fmac datapath.
//  - Accepts one fused op per valid/ready handshake and registers its operands.
//  - Applies the FMADD/FMSUB/FNMSUB/FNMADD sign rules and drives the fmac inputs.
//  - Waits C_LAT multicycle settling cycles, then captures result + OF/UF/NX.
//  - Returns them over a valid/ready handshake; optionally keeps sticky fflags.
// PARAMETERS
//  C_OP   32  operand/result width
//  C_RM   2   rounding-mode width
//  C_LAT  2   settle cycles for the fmac multicycle path; legal range 1..15
//  C_CNT  4   settle-counter width; must satisfy 2**C_CNT > C_LAT
// PORTS
//  Clk_CI        in   1     clock; single clock domain
//  Rst_RI        in   1     synchronous reset, active-high
//  Valid_SI      in   1     upstream op valid
//  Ready_SO      out  1     op accepted when Valid_SI && Ready_SO
//  Operand_a_DI  in   C_OP  addend
//  Operand_b_DI  in   C_OP  multiplicand
//  Operand_c_DI  in   C_OP  multiplier
//  Op_SI         in   2     0 FMADD, 1 FMSUB, 2 FNMSUB, 3 FNMADD
//  RM_SI         in   C_RM  rounding mode
//  Fmac_a_DO     out  C_OP  to fmac Operand_a_DI
//  Fmac_b_DO     out  C_OP  to fmac Operand_b_DI
//  Fmac_c_DO     out  C_OP  to fmac Operand_c_DI
//  Fmac_rm_SO    out  C_RM  to fmac RM_SI
//  Fmac_res_DI   in   32    from fmac Result_DO
//  Fmac_of_SI    in   1     from fmac Exp_OF_SO
//  Fmac_uf_SI    in   1     from fmac Exp_UF_SO
//  Fmac_nx_SI    in   1     from fmac Exp_NX_SO
//  Valid_SO      out  1     result valid
//  Ready_SI      in   1     downstream ready
//  Result_DO     out  32    registered result
//  Flags_DO      out  3     {OF,UF,NX} of this op
//  Fflags_DO     out  3     sticky {OF,UF,NX}; present only with FMAC_SEQ_STICKY_EN
//  Fflags_clr_SI in   1     clears sticky flags; present only with FMAC_SEQ_STICKY_EN
// BEHAVIOUR
//  Reset values
//   - State: IDLE; counter 0.
//   - Operand regs, RM reg, Result_DO, Flags_DO, Fflags_DO: 0.
//   - Valid_SO: 0. Ready_SO: 1.
//  FSM IDLE -> BUSY -> DONE
//   - IDLE: Ready_SO=1. On handshake, register operands with sign rules, load cnt=C_LAT-1, go BUSY.
//   - BUSY: Ready_SO=0. Decrement cnt each cycle.
//   - BUSY, cnt==0: capture Fmac_res_DI and {of,uf,nx} into output regs, go DONE.
//   - DONE: Valid_SO=1; Result_DO/Flags_DO held stable until Valid_SO && Ready_SI.
//   - DONE, Ready_SO = Ready_SI (combinational): output handshake and new-op accept may share a cycle.
//     Shared cycle goes BUSY; output handshake alone goes IDLE.
//  Latency
//   - Accept edge at cycle 0 -> Valid_SO high from cycle C_LAT.
//   - Throughput: one op per C_LAT+1 cycles when Ready_SI stays high.
//  Sign rules (fmac computes a + b*c)
//   - FMSUB: flip a[31].
//   - FNMSUB: flip b[31].
//   - FNMADD: flip a[31] and b[31].
//   - NaN operands are passed with the sign flipped; no other operand modification.
//  Other rules
//   - Fmac_*_DO come only from registers, stable over the whole BUSY/DONE window; no input-to-fmac comb path.
//   - Valid_SI in BUSY is ignored; the source must hold it until Ready_SO.
//   - Reset mid-op drops the op with no output: Valid_SO=0 in the next cycle.
// CONFIGURATION
//  `FMAC_SEQ_STICKY_EN defined
//   - Fflags_DO ORs in Flags at every result capture.
//   - Fflags_clr_SI zeroes it; clear and capture in the same cycle -> result = new flags only.
//  `FMAC_SEQ_STICKY_EN undefined
//   - Fflags_DO and Fflags_clr_SI ports and the sticky register are absent.
// STRUCTURE
//  - Shared package fpu_defs: op encodings (C_FMADD..C_FNMADD), FSM state typedef, flag bit indices.
//  - No sub-module; the counter and FSM stay inline.
//  - Top-level integration instantiates fmac next to this block and wires Fmac_* directly.
// TESTING
//  - FMADD a=0x3F800000 b=0x40000000 c=0x40400000 RM=0, C_LAT=2 -> Result 0x40E00000, Flags 0, Valid_SO at cycle 2.
//  - Same operands, FMSUB -> 0x40A00000; FNMSUB -> 0xC0A00000; FNMADD -> 0xC0E00000.
//  - a=0, b=c=0x7F000000 -> 0x7F800000, Flags=3'b101; Fflags=3'b101 with STICKY_EN.
//  - Ready_SI held low 5 cycles in DONE -> Result_DO stable, Ready_SO=0, second Valid_SI not accepted.
//    Then Ready_SI=1 -> back-to-back accept in the same cycle.
//  - Rst_RI pulsed while BUSY -> no Valid_SO; next op returns the correct result.
//  - Fflags_clr_SI coincident with an NX-only capture (a=0x3F800000, b=0x3F800001, c=0x3F800001)
//    -> Fflags=3'b001; with the macro undefined, the bench compiles without the ports.

Source files
------------

// File: rtl/fpu_defs.sv
// Shared FPU definitions: fused-op encodings, sequencer FSM states, flag bit indices
// and the sign-rule helpers used by fmac_seq.
package fpu_defs;

  localparam logic [1:0] C_FMADD  = 2'd0;
  localparam logic [1:0] C_FMSUB  = 2'd1;
  localparam logic [1:0] C_FNMSUB = 2'd2;
  localparam logic [1:0] C_FNMADD = 2'd3;

  localparam int unsigned C_FLAG_OF = 2;
  localparam int unsigned C_FLAG_UF = 1;
  localparam int unsigned C_FLAG_NX = 0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } seq_state_e;

  // The addend sign is inverted for the subtracting forms (a + b*c -> -a + b*c etc.)
  function automatic logic flipA(input logic [1:0] op);
    return (op == C_FMSUB) || (op == C_FNMADD);
  endfunction

  function automatic logic flipB(input logic [1:0] op);
    return (op == C_FNMSUB) || (op == C_FNMADD);
  endfunction

endpackage

// File: rtl/fmac_seq.sv
// fmac_seq: valid/ready sequencing stage wrapped around the combinational fmac datapath.
// Sticky fflags (Fflags_DO / Fflags_clr_SI) exist only when FMAC_SEQ_STICKY_EN is defined.
module fmac_seq
  import fpu_defs::*;
#(
  parameter int unsigned C_OP  = 32,
  parameter int unsigned C_RM  = 2,
  parameter int unsigned C_LAT = 2,
  parameter int unsigned C_CNT = 4
) (
  input  logic            Clk_CI,
  input  logic            Rst_RI,
  input  logic            Valid_SI,
  output logic            Ready_SO,
  input  logic [C_OP-1:0] Operand_a_DI,
  input  logic [C_OP-1:0] Operand_b_DI,
  input  logic [C_OP-1:0] Operand_c_DI,
  input  logic [1:0]      Op_SI,
  input  logic [C_RM-1:0] RM_SI,
  output logic [C_OP-1:0] Fmac_a_DO,
  output logic [C_OP-1:0] Fmac_b_DO,
  output logic [C_OP-1:0] Fmac_c_DO,
  output logic [C_RM-1:0] Fmac_rm_SO,
  input  logic [31:0]     Fmac_res_DI,
  input  logic            Fmac_of_SI,
  input  logic            Fmac_uf_SI,
  input  logic            Fmac_nx_SI,
  output logic            Valid_SO,
  input  logic            Ready_SI,
`ifdef FMAC_SEQ_STICKY_EN
  output logic [2:0]      Fflags_DO,
  input  logic            Fflags_clr_SI,
`endif
  output logic [31:0]     Result_DO,
  output logic [2:0]      Flags_DO
);

  localparam logic [C_OP-1:0] C_SIGN_MASK = {1'b1, {(C_OP-1){1'b0}}};
  localparam logic [C_CNT-1:0] C_CNT_LOAD = C_CNT'(C_LAT - 1);

  seq_state_e       state_q, state_d;
  logic [C_CNT-1:0] cnt_q, cnt_d;
  logic [C_OP-1:0]  a_q, a_d, b_q, b_d, c_q, c_d;
  logic [C_RM-1:0]  rm_q, rm_d;
  logic [31:0]      res_q, res_d;
  logic [2:0]       flags_q, flags_d;
  logic [2:0]       newFlags;
  logic             capture;
  logic             readyComb;
  logic             validComb;

  always_comb begin
    newFlags            = '0;
    newFlags[C_FLAG_OF] = Fmac_of_SI;
    newFlags[C_FLAG_UF] = Fmac_uf_SI;
    newFlags[C_FLAG_NX] = Fmac_nx_SI;
  end

  // In DONE the accept path follows Ready_SI so a result drain and a new accept share a cycle.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    a_d       = a_q;
    b_d       = b_q;
    c_d       = c_q;
    rm_d      = rm_q;
    res_d     = res_q;
    flags_d   = flags_q;
    capture   = 1'b0;
    readyComb = 1'b0;
    validComb = 1'b0;

    unique case (state_q)
      IDLE: readyComb = 1'b1;
      BUSY: begin
        if (cnt_q == '0) begin
          capture = 1'b1;
          res_d   = Fmac_res_DI;
          flags_d = newFlags;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      DONE: begin
        validComb = 1'b1;
        readyComb = Ready_SI;
        if (Ready_SI) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (readyComb && Valid_SI) begin
      a_d     = Operand_a_DI ^ (flipA(Op_SI) ? C_SIGN_MASK : '0);
      b_d     = Operand_b_DI ^ (flipB(Op_SI) ? C_SIGN_MASK : '0);
      c_d     = Operand_c_DI;
      rm_d    = RM_SI;
      cnt_d   = C_CNT_LOAD;
      state_d = BUSY;
    end
  end

  always_ff @(posedge Clk_CI) begin
    if (Rst_RI) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= '0;
      rm_q    <= '0;
      res_q   <= '0;
      flags_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
      rm_q    <= rm_d;
      res_q   <= res_d;
      flags_q <= flags_d;
    end
  end

`ifdef FMAC_SEQ_STICKY_EN
  logic [2:0] fflags_q, fflags_d;

  // Clear first, then OR the capture in, so a coincident clear keeps only the new flags.
  always_comb begin
    fflags_d = fflags_q;
    if (Fflags_clr_SI) fflags_d = '0;
    if (capture) fflags_d = fflags_d | newFlags;
  end

  always_ff @(posedge Clk_CI) begin
    if (Rst_RI) fflags_q <= '0;
    else        fflags_q <= fflags_d;
  end

  assign Fflags_DO = fflags_q;
`endif

  assign Ready_SO   = readyComb;
  assign Valid_SO   = validComb;
  assign Fmac_a_DO  = a_q;
  assign Fmac_b_DO  = b_q;
  assign Fmac_c_DO  = c_q;
  assign Fmac_rm_SO = rm_q;
  assign Result_DO  = res_q;
  assign Flags_DO   = flags_q;

endmodule
